// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings the system PLL from power-up to a qualified,
// running state. Pulses the PLL reset, waits for a synchronized lock, requires
// it to stay stable for a window, then releases the downstream system reset.
// Lock timeouts are retried a bounded number of times before latching FAIL.
// Loss of lock in RUN, or a software relock request, restarts the sequence.
// Optional build macro: PLL_LOSS_COUNTER_EN enables the saturating
// loss-of-lock event counter on lock_loss_cnt (tied to zero otherwise).
`timescale 1ns/1ps
module pll_lock_sequencer #(
   parameter int RST_CYCLES          = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRIES         = 3
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       relock_req,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic       fail,
   output logic [7:0] retry_cnt,
   output logic [7:0] lock_loss_cnt
);

   // Counter is sized for the longest interval we ever have to measure.
   localparam int MAX_AB    = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int MAX_COUNT = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
   localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       RETRY_MAX = 8'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABILIZE,
      S_RUN,
      S_FAIL
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       retry_q, retry_d;
   logic [1:0]       sync_q, sync_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_q, sys_rst_d;
   logic             ready_q, ready_d;
   logic             fail_q, fail_d;
   logic             locked_s;

   // The raw lock is asynchronous to refclk; only the second stage is used.
   always_comb begin
      sync_d = {sync_q[0], pll_locked};
   end
   assign locked_s = sync_q[1];

   // Next-state, counter and retry bookkeeping; outputs follow the next state
   // so that every output changes on the same edge as the state it reflects.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      retry_d = retry_q;

      if (relock_req && (state_q != S_RESET_PLL)) begin
         // Software relock overrides everything except a pulse already running.
         state_d = S_RESET_PLL;
         retry_d = 8'd0;
      end else begin
         case (state_q)
            S_RESET_PLL: begin
               if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               // A lock seen on the timeout cycle wins over the timeout.
               if (locked_s) begin
                  state_d = S_STABILIZE;
               end else if (cnt_q == TO_LAST) begin
                  if (retry_q == RETRY_MAX) begin
                     state_d = S_FAIL;
                  end else begin
                     state_d = S_RESET_PLL;
                     retry_d = retry_q + 8'd1;
                  end
               end
            end
            S_STABILIZE: begin
               if (!locked_s) state_d = S_WAIT_LOCK;
               else if (cnt_q == STAB_LAST) state_d = S_RUN;
            end
            S_RUN: begin
               if (!locked_s) state_d = S_RESET_PLL;
            end
            S_FAIL: begin
               state_d = S_FAIL;
            end
            default: begin
               state_d = S_RESET_PLL;
            end
         endcase
      end

      // Every state starts its interval from zero; RUN and FAIL do not count.
      if ((state_d != state_q) || (state_q == S_RUN) || (state_q == S_FAIL)) begin
         cnt_d = '0;
      end
      if (state_d == S_RUN) retry_d = 8'd0;

      pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_d = (state_d != S_RUN);
      ready_d   = (state_d == S_RUN);
      fail_d    = (state_d == S_FAIL);
   end

   // State and output registers, all cleared asynchronously to the safe state.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q   <= S_RESET_PLL;
         cnt_q     <= '0;
         retry_q   <= 8'd0;
         sync_q    <= 2'b00;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
         fail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         sync_q    <= sync_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
         fail_q    <= fail_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

`ifdef PLL_LOSS_COUNTER_EN
   logic [7:0] loss_q, loss_d;
   logic       loss_event;

   // Any cycle in RUN without lock leaves RUN, with or without a relock request.
   assign loss_event = (state_q == S_RUN) && !locked_s;

   // Saturating count of lock losses; only rst clears it.
   always_comb begin
      loss_d = loss_q;
      if (loss_event && (loss_q != 8'hFF)) loss_d = loss_q + 8'd1;
   end

   // Loss counter register.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) loss_q <= 8'd0;
      else     loss_q <= loss_d;
   end

   assign lock_loss_cnt = loss_q;
`else
   assign lock_loss_cnt = 8'd0;
`endif

endmodule
